counter_dir_decoder: RTL and testbench
======================================

// Module: counter_dir_decoder
// PURPOSE
//  Far-end decoder for the 4-bit up/down counter: samples the counter's dout and rst every clk and
//  recovers the applied direction (up) one step at a time. Flags illegal steps (not +1, -1 or a reset
//  to 0), counts them, and tracks same-direction run length. Sits in the checker/monitor path
//  beside the counter.
// PARAMETERS
//  W         4   counter width; must be >= 2 (for W=1, +1 and -1 are indistinguishable)
//  ERR_W     8   width of err_count (saturating)
//  RUN_W     8   width of run_len (saturating)
//  MAX_ERR   3   consecutive illegal steps that force loss of lock (1..2^ERR_W-1)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  cnt_in     in   W      counter dout, sampled every posedge
//  cnt_rst    in   1      counter's rst, sampled on the same edge as cnt_in
//  locked     out  1      decoder has a valid previous sample and is tracking
//  dir_valid  out  1      1-cycle strobe: dir_up holds a decoded step
//  dir_up     out  1      decoded direction (1=+1, 0=-1); held between strobes
//  dir_chg    out  1      1-cycle strobe: decoded direction differs from last decoded one
//  err        out  1      1-cycle strobe: illegal step detected
//  err_count  out  ERR_W  total illegal steps since rst, saturates at all-ones
//  run_len    out  RUN_W  consecutive steps in current direction, saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=ACQ; locked, dir_valid, dir_up, dir_chg, err = 0;
//   err_count = 0; run_len = 0; prev sample and rst_d cleared. rst wins over every other event.
//  State ACQ: capture prev<=cnt_in, rst_d<=cnt_rst; go TRACK next cycle; no strobes.
//  State TRACK, per posedge, with d = cnt_in - prev (mod 2^W), in priority order:
//   1. rst_d=1: legal only if cnt_in==0 -> no strobe, run_len<=0, consec-err<=0, direction
//      history cleared (next decoded step never raises dir_chg); cnt_in!=0 -> illegal (rule 4).
//   2. d==1      -> dir_valid=1, dir_up=1.
//   3. d==2^W-1  -> dir_valid=1, dir_up=0.
//   4. else (incl. d==0) -> err=1, err_count+=1 (sat), run_len<=0, consec-err+=1;
//      consec-err reaching MAX_ERR -> state ACQ, locked=0 next cycle.
//   On a legal step: consec-err<=0; if history valid and new dir==last dir -> run_len+=1 (sat),
//    else run_len<=1 and dir_chg=1 only when history was valid.
//   Always prev<=cnt_in, rst_d<=cnt_rst.
//  Wrap-around: 2^W-1 -> 0 decodes up; 0 -> 2^W-1 decodes down; never an error.
//  Latency: step sampled at edge k (prev from edge k-1) -> strobes valid after edge k, one cycle wide.
//  locked=1 exactly while state==TRACK. All outputs registered; no combinational in->out path.
//  rst mid-run discards all history; first decode needs two post-reset samples.
// STRUCTURE
//  counter_pkg: typedef enum logic {DEC_ACQ, DEC_TRACK} dec_state_e; typedef enum logic [1:0]
//   {STEP_UP, STEP_DN, STEP_RST, STEP_BAD} step_e; localparam default W.
//  Sub-module sat_counter #(N) (clk, rst, clr, inc, q): used for err_count, run_len, consec-err.
//  Top: step classifier (comb, returns step_e), state register, output registers.
// TESTING
//  rst, then cnt_in 0,1,2,3 (cnt_rst=0) -> locked after edge 2; dir_valid,dir_up=1 x3; run_len=3; err=0
//  cnt_in 14,15,0,15,14 -> up,up,down(dir_chg=1,run_len=1),down(run_len=2); no err at 15<->0 wraps
//  cnt_in 5,9 -> err=1, err_count=1, run_len=0, dir_valid=0; next 10 -> up, locked stays 1
//  3 consecutive bad steps 2,7,12,4 -> err x3, locked=0 next cycle, ACQ, relock after 1 sample
//  cnt_rst=1 at cnt_in=7, next cnt_in=0 -> no err, run_len=0; next 1 -> up with dir_chg=0
//  cnt_rst=1 then cnt_in=6 -> err=1; rst pulse mid-run -> all outputs 0, err_count=0

Source files
------------

// File: rtl/counter_dir_decoder_pkg.sv
// Shared types and defaults for the up/down counter direction decoder.
package counter_dir_decoder_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic {DEC_ACQ, DEC_TRACK} dec_state_e;

  typedef enum logic [1:0] {STEP_UP, STEP_DN, STEP_RST, STEP_BAD} step_e;

endpackage

// File: rtl/counter_dir_decoder_if.sv
// Sampled counter signals (master side) and decoded results (slave side).
interface counter_dir_decoder_if
  import counter_dir_decoder_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int ERR_W = 8,
  parameter int RUN_W = 8
);
  logic [W-1:0]     cnt_in;
  logic             cnt_rst;
  logic             locked;
  logic             dir_valid;
  logic             dir_up;
  logic             dir_chg;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [RUN_W-1:0] run_len;

  modport master (
    output cnt_in, cnt_rst,
    input  locked, dir_valid, dir_up, dir_chg, err, err_count, run_len
  );

  modport slave (
    input  cnt_in, cnt_rst,
    output locked, dir_valid, dir_up, dir_chg, err, err_count, run_len
  );
endinterface

// File: rtl/counter_dir_decoder_sat_counter.sv
// Saturating up-counter; clr together with inc loads 1 so a run can restart in one cycle.
module sat_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? N'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end
endmodule

// File: rtl/counter_dir_decoder.sv
// Far-end decoder: recovers counter direction from successive samples and flags illegal steps.
module counter_dir_decoder
  import counter_dir_decoder_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int ERR_W   = 8,
  parameter int RUN_W   = 8,
  parameter int MAX_ERR = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_dir_decoder_if.slave bus
);
  dec_state_e       state, state_next;
  step_e            step;
  logic [W-1:0]     prev;
  logic [W-1:0]     d;
  logic             rst_d;
  logic             hist_valid;
  logic             tracking, legal, bad, rst_step, new_up, same_dir;
  logic             run_clr, cons_clr;
  logic             dir_valid_q, dir_up_q, dir_chg_q, err_q;
  logic [ERR_W-1:0] err_count_q, cons_q;
  logic [RUN_W-1:0] run_len_q;

  always_comb begin
    d    = bus.cnt_in - prev;
    step = STEP_BAD;
    if (rst_d) begin
      step = (bus.cnt_in == '0) ? STEP_RST : STEP_BAD;
    end else if (d == W'(1)) begin
      step = STEP_UP;
    end else if (d == '1) begin
      step = STEP_DN;
    end
  end

  always_comb begin
    tracking = (state == DEC_TRACK);
    legal    = tracking && ((step == STEP_UP) || (step == STEP_DN));
    bad      = tracking && (step == STEP_BAD);
    rst_step = tracking && (step == STEP_RST);
    new_up   = (step == STEP_UP);
    same_dir = hist_valid && (new_up == dir_up_q);
    // Clearing with inc set loads 1: start of a fresh run in the new direction.
    run_clr  = !tracking || bad || rst_step || (legal && !same_dir);
    cons_clr = !tracking || legal || rst_step;
    state_next = state;
    case (state)
      DEC_ACQ:   state_next = DEC_TRACK;
      DEC_TRACK: if (bad && (cons_q == ERR_W'(MAX_ERR - 1))) state_next = DEC_ACQ;
      default:   state_next = DEC_ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DEC_ACQ;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev        <= '0;
      rst_d       <= 1'b0;
      hist_valid  <= 1'b0;
      dir_valid_q <= 1'b0;
      dir_up_q    <= 1'b0;
      dir_chg_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev        <= bus.cnt_in;
      rst_d       <= bus.cnt_rst;
      dir_valid_q <= legal;
      dir_chg_q   <= legal && hist_valid && (new_up != dir_up_q);
      err_q       <= bad;
      if (legal) begin
        dir_up_q   <= new_up;
        hist_valid <= 1'b1;
      end else if (rst_step || !tracking) begin
        hist_valid <= 1'b0;
      end
    end
  end

  sat_counter #(.N(ERR_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(bad), .q(err_count_q)
  );

  sat_counter #(.N(RUN_W)) u_run_cnt (
    .clk(clk), .rst(rst), .clr(run_clr), .inc(legal), .q(run_len_q)
  );

  sat_counter #(.N(ERR_W)) u_cons_cnt (
    .clk(clk), .rst(rst), .clr(cons_clr), .inc(bad), .q(cons_q)
  );

  assign bus.locked    = (state == DEC_TRACK);
  assign bus.dir_valid = dir_valid_q;
  assign bus.dir_up    = dir_up_q;
  assign bus.dir_chg   = dir_chg_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
  assign bus.run_len   = run_len_q;
endmodule

// File: tb/tb_counter_dir_decoder.sv
// Directed vector bench for counter_dir_decoder: table of steps plus saturation sequences.
module tb_counter_dir_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  counter_dir_decoder_if #(.W(4), .ERR_W(8), .RUN_W(8)) bus ();

  counter_dir_decoder #(.W(4), .ERR_W(8), .RUN_W(8), .MAX_ERR(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] c;
    logic       cr;
    logic       lk, dv, up, chg, er;
    logic [7:0] ec, rl;
  } vec_t;

  vec_t v[29];

  function automatic vec_t mk(input int r, c, cr, lk, dv, up, chg, er, ec, rl);
    vec_t t;
    t.r = r[0]; t.c = c[3:0]; t.cr = cr[0];
    t.lk = lk[0]; t.dv = dv[0]; t.up = up[0]; t.chg = chg[0]; t.er = er[0];
    t.ec = ec[7:0]; t.rl = rl[7:0];
    return t;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] c, input logic cr);
    @(negedge clk);
    rst = r; bus.cnt_in = c; bus.cnt_rst = cr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst cnt cr  lk dv up chg er ec rl
    v[0]  = mk(1,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    v[1]  = mk(0,  0,  0,  1, 0, 0, 0, 0, 0, 0);
    v[2]  = mk(0,  1,  0,  1, 1, 1, 0, 0, 0, 1);
    v[3]  = mk(0,  2,  0,  1, 1, 1, 0, 0, 0, 2);
    v[4]  = mk(0,  3,  0,  1, 1, 1, 0, 0, 0, 3);
    v[5]  = mk(1, 14,  0,  0, 0, 0, 0, 0, 0, 0);
    v[6]  = mk(0, 14,  0,  1, 0, 0, 0, 0, 0, 0);
    v[7]  = mk(0, 15,  0,  1, 1, 1, 0, 0, 0, 1);
    v[8]  = mk(0,  0,  0,  1, 1, 1, 0, 0, 0, 2);
    v[9]  = mk(0, 15,  0,  1, 1, 0, 1, 0, 0, 1);
    v[10] = mk(0, 14,  0,  1, 1, 0, 0, 0, 0, 2);
    v[11] = mk(1,  4,  0,  0, 0, 0, 0, 0, 0, 0);
    v[12] = mk(0,  4,  0,  1, 0, 0, 0, 0, 0, 0);
    v[13] = mk(0,  5,  0,  1, 1, 1, 0, 0, 0, 1);
    v[14] = mk(0,  9,  0,  1, 0, 1, 0, 1, 1, 0);
    v[15] = mk(0, 10,  0,  1, 1, 1, 0, 0, 1, 1);
    v[16] = mk(0,  2,  0,  1, 0, 1, 0, 1, 2, 0);
    v[17] = mk(0,  7,  0,  1, 0, 1, 0, 1, 3, 0);
    v[18] = mk(0, 12,  0,  0, 0, 1, 0, 1, 4, 0);
    v[19] = mk(0,  4,  0,  1, 0, 1, 0, 0, 4, 0);
    v[20] = mk(0,  5,  0,  1, 1, 1, 0, 0, 4, 1);
    v[21] = mk(0,  6,  0,  1, 1, 1, 0, 0, 4, 2);
    v[22] = mk(0,  7,  1,  1, 1, 1, 0, 0, 4, 3);
    v[23] = mk(0,  0,  0,  1, 0, 1, 0, 0, 4, 0);
    v[24] = mk(0, 15,  0,  1, 1, 0, 0, 0, 4, 1);
    v[25] = mk(0, 14,  1,  1, 1, 0, 0, 0, 4, 2);
    v[26] = mk(0,  6,  0,  1, 0, 0, 0, 1, 5, 0);
    v[27] = mk(0,  5,  0,  1, 1, 0, 0, 0, 5, 1);
    v[28] = mk(1,  5,  0,  0, 0, 0, 0, 0, 0, 0);

    bus.cnt_in = '0;
    bus.cnt_rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      drive(v[i].r, v[i].c, v[i].cr);
      check("locked",    i, int'(bus.locked),    int'(v[i].lk));
      check("dir_valid", i, int'(bus.dir_valid), int'(v[i].dv));
      check("dir_up",    i, int'(bus.dir_up),    int'(v[i].up));
      check("dir_chg",   i, int'(bus.dir_chg),   int'(v[i].chg));
      check("err",       i, int'(bus.err),       int'(v[i].er));
      check("err_count", i, int'(bus.err_count), int'(v[i].ec));
      check("run_len",   i, int'(bus.run_len),   int'(v[i].rl));
    end

    // Long monotonic up run: run_len must stick at all-ones.
    drive(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [3:0] c;
      c = 4'(i);
      drive(1'b0, c, 1'b0);
    end
    check("run_len_sat", 0, int'(bus.run_len), 255);
    check("run_err_count", 0, int'(bus.err_count), 0);
    check("run_dir_up", 0, int'(bus.dir_up), 1);

    // Stuck input: repeated lock loss every third error; err_count must saturate.
    drive(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 4'd3, 1'b0);
    check("stuck_locked_lost", 0, int'(bus.locked), 0);
    check("stuck_err_count", 0, int'(bus.err_count), 3);
    for (int i = 0; i < 400; i++) drive(1'b0, 4'd3, 1'b0);
    check("err_count_sat", 0, int'(bus.err_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule
